// File: rtl/disp_src_sel.sv
// Source selector for the two-digit hex display: picks one of four CPU bytes by
// debounced push-button, timed auto-scroll or freeze, and registers it onto data_out.
module disp_src_sel #(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int SCROLL_CYCLES   = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ip_in,
    input  logic [7:0] acc_in,
    input  logic [7:0] rega_in,
    input  logic [7:0] regb_in,
    input  logic       btn_next,
    input  logic       sw_auto,
    input  logic       sw_freeze,
    output logic [7:0] data_out,
    output logic [1:0] src_idx,
    output logic       frozen
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int SC_W = $clog2(SCROLL_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCROLL_CYCLES - 1);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            btn_meta, btn_sync;
    logic            auto_meta, auto_sync;
    logic            freeze_meta, freeze_sync;
    logic            db, db_q, press;
    logic [DB_W-1:0] db_cnt;
    logic [SC_W-1:0] scroll_cnt;
    logic [7:0]      src_val;

    // Input conditioning: two-flop synchronizers, debounce filter, rising-edge press pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_meta    <= 1'b0;
            btn_sync    <= 1'b0;
            auto_meta   <= 1'b0;
            auto_sync   <= 1'b0;
            freeze_meta <= 1'b0;
            freeze_sync <= 1'b0;
            db          <= 1'b0;
            db_q        <= 1'b0;
            db_cnt      <= '0;
            press       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the synchronizer chain shift one stage per edge
            // regardless of statement order; blocking ones would collapse it into a wire.
            btn_meta    <= btn_next;
            btn_sync    <= btn_meta;
            auto_meta   <= sw_auto;
            auto_sync   <= auto_meta;
            freeze_meta <= sw_freeze;
            freeze_sync <= freeze_meta;
            if (btn_sync == db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                db     <= ~db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            db_q  <= db;
            press <= db & ~db_q;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        unique case (state)
            MANUAL: if (freeze_sync) next_state = FROZEN;
                    else if (auto_sync) next_state = AUTO;
            AUTO:   if (freeze_sync) next_state = FROZEN;
                    else if (!auto_sync) next_state = MANUAL;
            FROZEN: if (!freeze_sync) next_state = auto_sync ? AUTO : MANUAL;
            default: next_state = MANUAL;
        endcase
    end

    always_comb begin
        unique case (src_idx)
            2'd0:    src_val = ip_in;
            2'd1:    src_val = acc_in;
            2'd2:    src_val = rega_in;
            default: src_val = regb_in;
        endcase
    end

    // Mode FSM with selection index, scroll timer and output byte all registered together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= MANUAL;
            frozen     <= 1'b0;
            src_idx    <= 2'd0;
            scroll_cnt <= '0;
            data_out   <= 8'h00;
        end else begin
            state  <= next_state;
            frozen <= (next_state == FROZEN);
            if (state != FROZEN) begin
                data_out <= src_val;
            end
            // Entering or sitting in FROZEN holds the index, even against a coincident press.
            if (next_state == FROZEN || state == FROZEN) begin
                scroll_cnt <= '0;
            end else if (state == AUTO) begin
                if (press || scroll_cnt == SC_MAX) begin
                    src_idx    <= src_idx + 2'd1;
                    scroll_cnt <= '0;
                end else begin
                    scroll_cnt <= scroll_cnt + 1'b1;
                end
            end else begin
                scroll_cnt <= '0;
                if (press) begin
                    src_idx <= src_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_disp_src_sel.sv
// Bench for disp_src_sel: directed scenarios with fixed expectations plus a randomized
// run compared cycle-by-cycle against a mode-level behavioural model.
module tb_disp_src_sel;

    localparam int DEB = 4;
    localparam int SCR = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ip_in, acc_in, rega_in, regb_in;
    logic       btn_next, sw_auto, sw_freeze;
    logic [7:0] data_out;
    logic [1:0] src_idx;
    logic       frozen;

    int n_total = 0;
    int n_bad   = 0;

    disp_src_sel #(.DEBOUNCE_CYCLES(DEB), .SCROLL_CYCLES(SCR)) dut (
        .clk(clk), .rst_n(rst_n),
        .ip_in(ip_in), .acc_in(acc_in), .rega_in(rega_in), .regb_in(regb_in),
        .btn_next(btn_next), .sw_auto(sw_auto), .sw_freeze(sw_freeze),
        .data_out(data_out), .src_idx(src_idx), .frozen(frozen)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0=manual, 1=auto, 2=frozen.
    logic       m_bs1, m_bs2, m_as1, m_as2, m_fs1, m_fs2;
    logic       m_db, m_db_q, m_press;
    int         m_run, m_cnt, m_mode, m_mode_next;
    logic [1:0] m_src;
    logic [7:0] m_data;
    logic       m_frozen;
    logic [7:0] m_val;

    always_comb begin
        m_mode_next = m_fs2 ? 2 : (m_as2 ? 1 : 0);
        case (m_src)
            2'd0:    m_val = ip_in;
            2'd1:    m_val = acc_in;
            2'd2:    m_val = rega_in;
            default: m_val = regb_in;
        endcase
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            {m_bs1, m_bs2, m_as1, m_as2, m_fs1, m_fs2} <= '0;
            m_db <= 0; m_db_q <= 0; m_press <= 0; m_run <= 0; m_cnt <= 0;
            m_mode <= 0; m_src <= 0; m_data <= 0; m_frozen <= 0;
        end else begin
            m_bs1 <= btn_next;  m_bs2 <= m_bs1;
            m_as1 <= sw_auto;   m_as2 <= m_as1;
            m_fs1 <= sw_freeze; m_fs2 <= m_fs1;
            if (m_bs2 == m_db) m_run <= 0;
            else if (m_run == DEB - 1) begin m_db <= !m_db; m_run <= 0; end
            else m_run <= m_run + 1;
            m_db_q   <= m_db;
            m_press  <= m_db && !m_db_q;
            m_mode   <= m_mode_next;
            m_frozen <= (m_mode_next == 2);
            if (m_mode != 2) m_data <= m_val;
            if (m_mode_next == 2 || m_mode == 2) m_cnt <= 0;
            else if (m_mode == 1) begin
                if (m_press || m_cnt == SCR - 1) begin m_src <= m_src + 2'd1; m_cnt <= 0; end
                else m_cnt <= m_cnt + 1;
            end else begin
                m_cnt <= 0;
                if (m_press) m_src <= m_src + 2'd1;
            end
        end
    end

    task automatic do_press();
        btn_next = 1'b1;
        repeat (10) @(negedge clk);
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ip_in = 8'hA5; acc_in = 8'h00; rega_in = 8'h00; regb_in = 8'h00;
        btn_next = 0; sw_auto = 0; sw_freeze = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if ({data_out, src_idx, frozen} !== 11'h0) begin
                n_bad++;
                $display("FAIL reset_outputs: got data=%h idx=%0d frz=%b want 00/0/0", data_out, src_idx, frozen);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (data_out !== 8'hA5) begin
            n_bad++;
            $display("FAIL reset_release_data: got %h want a5", data_out);
        end
    endtask

    task automatic test_debounce();
        acc_in = 8'h3C;
        for (int r = 0; r < 4; r++) begin
            btn_next = 1'b1; repeat (3) @(negedge clk);
            btn_next = 1'b0; repeat (2) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        n_total++;
        if (src_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL bounce_rejected: got idx=%0d want 0", src_idx);
        end
        btn_next = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 7 || k == 8 || k == 20) begin
                n_total++;
                if (src_idx !== ((k == 7) ? 2'd0 : 2'd1)) begin
                    n_bad++;
                    $display("FAIL press_latency_e%0d: got idx=%0d want %0d", k, src_idx, (k == 7) ? 0 : 1);
                end
            end
            if (k == 9) begin
                n_total++;
                if (data_out !== 8'h3C) begin
                    n_bad++;
                    $display("FAIL press_data: got %h want 3c", data_out);
                end
            end
        end
        btn_next = 1'b0;
        repeat (15) @(negedge clk);
        n_total++;
        if (src_idx !== 2'd1) begin
            n_bad++;
            $display("FAIL release_no_press: got idx=%0d want 1", src_idx);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_data [4];
        exp_data[0] = 8'h22; exp_data[1] = 8'h33; exp_data[2] = 8'h44; exp_data[3] = 8'h11;
        rst_n = 1'b0; repeat (2) @(negedge clk); rst_n = 1'b1;
        ip_in = 8'h11; acc_in = 8'h22; rega_in = 8'h33; regb_in = 8'h44;
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            do_press();
            n_total++;
            if (src_idx !== 2'(p + 1) || data_out !== exp_data[p]) begin
                n_bad++;
                $display("FAIL wrap_p%0d: got idx=%0d data=%h want %0d/%h", p, src_idx, data_out, (p + 1) % 4, exp_data[p]);
            end
        end
    endtask

    task automatic test_auto_scroll();
        int k;
        logic [1:0] s0;
        sw_auto = 1'b1;
        s0 = src_idx; k = 0;
        do begin @(negedge clk); k++; end while (src_idx == s0 && k < 40);
        n_total++;
        if (k != 13 || src_idx !== s0 + 2'd1) begin
            n_bad++;
            $display("FAIL auto_first_step: got edges=%0d idx=%0d want 13/%0d", k, src_idx, s0 + 2'd1);
        end
        for (int s = 0; s < 4; s++) begin
            s0 = src_idx; k = 0;
            do begin @(negedge clk); k++; end while (src_idx == s0 && k < 40);
            n_total++;
            if (k != SCR || src_idx !== s0 + 2'd1) begin
                n_bad++;
                $display("FAIL auto_step%0d: got edges=%0d idx=%0d want %0d/%0d", s, k, src_idx, SCR, s0 + 2'd1);
            end
        end
        // Time a press so its pulse lands on the scroll-wrap cycle.
        s0 = src_idx;
        repeat (2) @(negedge clk);
        btn_next = 1'b1; k = 2;
        do begin @(negedge clk); k++; end while (src_idx == s0 && k < 40);
        n_total++;
        if (k != SCR || src_idx !== s0 + 2'd1) begin
            n_bad++;
            $display("FAIL auto_press_on_wrap: got edges=%0d idx=%0d want %0d/%0d", k, src_idx, SCR, s0 + 2'd1);
        end
        btn_next = 1'b0;
        s0 = src_idx; k = 0;
        do begin @(negedge clk); k++; end while (src_idx == s0 && k < 40);
        n_total++;
        if (k != SCR || src_idx !== s0 + 2'd1) begin
            n_bad++;
            $display("FAIL auto_after_coincide: got edges=%0d idx=%0d want %0d/%0d", k, src_idx, SCR, s0 + 2'd1);
        end
    endtask

    task automatic test_freeze();
        int k;
        k = 0;
        while (src_idx !== 2'd1 && k < 50) begin @(negedge clk); k++; end
        sw_freeze = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (frozen !== 1'b1 && k < 20);
        n_total++;
        if (k != 3 || data_out !== 8'h22) begin
            n_bad++;
            $display("FAIL freeze_enter: got edges=%0d data=%h want 3/22", k, data_out);
        end
        acc_in = 8'hFF;
        repeat (5) @(negedge clk);
        do_press();
        n_total++;
        if (data_out !== 8'h22 || src_idx !== 2'd1 || frozen !== 1'b1) begin
            n_bad++;
            $display("FAIL freeze_hold: got data=%h idx=%0d frz=%b want 22/1/1", data_out, src_idx, frozen);
        end
        sw_freeze = 1'b0;
        k = 0;
        do begin
            @(negedge clk); k++;
            if (k == 5) begin
                n_total++;
                if (data_out !== 8'hFF || frozen !== 1'b0) begin
                    n_bad++;
                    $display("FAIL unfreeze_live: got data=%h frz=%b want ff/0", data_out, frozen);
                end
            end
        end while (src_idx == 2'd1 && k < 40);
        n_total++;
        if (k != 13 || src_idx !== 2'd2) begin
            n_bad++;
            $display("FAIL unfreeze_restart: got edges=%0d idx=%0d want 13/2", k, src_idx);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        logic [1:0] s0;
        s0 = src_idx; k = 0;
        do begin @(negedge clk); k++; end while (src_idx == s0 && k < 20);
        repeat (3) @(negedge clk);
        btn_next = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0; btn_next = 1'b0; sw_auto = 1'b0; ip_in = 8'h5A;
        repeat (3) @(negedge clk);
        n_total++;
        if ({data_out, src_idx, frozen} !== 11'h0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got data=%h idx=%0d frz=%b want 00/0/0", data_out, src_idx, frozen);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_total++;
        if (src_idx !== 2'd0 || data_out !== 8'h5A || frozen !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_no_press: got idx=%0d data=%h frz=%b want 0/5a/0", src_idx, data_out, frozen);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            n_total++;
            if ({data_out, src_idx, frozen} !== {m_data, m_src, m_frozen}) begin
                n_bad++;
                $display("FAIL random_c%0d: got data=%h idx=%0d frz=%b want %h/%0d/%b",
                         c, data_out, src_idx, frozen, m_data, m_src, m_frozen);
            end
            if ($urandom_range(5) == 0)   btn_next  = ~btn_next;
            if ($urandom_range(60) == 0)  sw_auto   = ~sw_auto;
            if ($urandom_range(90) == 0)  sw_freeze = ~sw_freeze;
            if ($urandom_range(7) == 0)   ip_in     = 8'($urandom);
            if ($urandom_range(7) == 0)   acc_in    = 8'($urandom);
            if ($urandom_range(7) == 0)   rega_in   = 8'($urandom);
            if ($urandom_range(7) == 0)   regb_in   = 8'($urandom);
            rst_n = ($urandom_range(400) != 0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_wrap();
        test_auto_scroll();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
